pwm_ramp_sequencer: RTL and testbench
=====================================

# pwm_ramp_sequencer

Duty-cycle sequencer for the PWM generator. It accepts a target duty percentage (0–100) and a ramp rate over a valid/ready command port. It then walks the applied duty toward the target one percent at a time, and changes it only at PWM period boundaries so no output period is ever glitched. It owns the 8-bit period counter; the PWM core compares `cnt` against the threshold derived from `duty`.

## Interface
- `CNT_W`, 8: period counter width; period = 2^CNT_W cycles.
- `DC_MAX`, 100: maximum duty value; larger targets are clamped to this.
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: reset is synchronous and active-low.
- `en` in 1: 1 = run; 0 = freeze the counter and all state.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: combinational, = `en` && state==IDLE.
- `cmd_target` in 7: requested duty, 0–127; values above 100 are clamped to 100.
- `cmd_rate` in 4: boundaries waited per step minus one; 0 = jump directly.
- `cnt` out CNT_W: free-running period counter.
- `period_start` out 1: combinational, = (`cnt`==0).
- `duty` out 7: applied duty, registered, 0–100.
- `busy` out 1: registered, 1 while state==RAMP.
- `done` out 1: registered one-cycle pulse when a command completes.

## Operation
- **Reset** (`rst_n`=0 at a clock edge): `cnt`=0, `duty`=0, state=IDLE, `busy`=0, `done`=0, target=0, `wait_cnt`=0. Hence `period_start`=1, and `cmd_ready`=`en`.
- **Counter**: `cnt` increments by 1 each edge with `en`=1. It wraps from 2^CNT_W−1 to 0.
- **Boundary edge**: an edge with `en`=1 and `cnt`=2^CNT_W−1.
- **`en`=0**: `cnt`, `duty`, state and `wait_cnt` all hold, and `cmd_ready`=0. `done` still clears after its one-cycle pulse.
- **States**: IDLE and RAMP.
- **IDLE, accept** (`cmd_valid`&&`cmd_ready` at an edge):
  - Latch tgt = min(`cmd_target`, 100), `rate`=`cmd_rate`, and load `wait_cnt`=`cmd_rate`.
  - If tgt==`duty`: stay in IDLE and pulse `done` next cycle; `busy` stays 0.
  - Otherwise: go to RAMP and set `busy`=1.
  - An accept edge that is also a boundary edge does not count as a ramp boundary.
- **RAMP, at each boundary edge**:
  - If `rate`==0: `duty`←tgt.
  - Else if `wait_cnt`≠0: `wait_cnt`←`wait_cnt`−1.
  - Else: `duty`←`duty`±1 toward tgt, and `wait_cnt`←`rate`.
  - If the new `duty` equals tgt: go to IDLE, `busy`←0, `done`←1 for one cycle.
- **RAMP, other edges**: no change. `cmd_valid` is ignored because `cmd_ready`=0; no abort or retarget is possible.
- **Arithmetic**: `duty` never leaves 0..100, and the step never overshoots tgt. `wait_cnt` is 4 bits.

## Timing
- Accept latency: `busy` rises the cycle after the accept edge.
- Step pacing for `rate`=R>0:
  - First step at the (R+1)th boundary edge after accept; each later step every R+1 boundaries.
  - A ramp of |Δ| steps completes in (R+1)·|Δ| boundaries.
- Step pacing for `rate`=0: completes at the first boundary edge after accept.
- `duty` changes only on boundary edges, so a new value is first visible in the cycle `cnt`==0 (`period_start`=1).
- `done` is high in the same cycle the final `duty` first appears. `busy` falls in that cycle and `cmd_ready` returns then.
- Equal-target command: `done` is high the cycle after accept.
- Back-to-back commands: a new command may be accepted in the `done` cycle.
- Reset during RAMP: immediate abandon. All outputs take their reset values at that edge; no `done` pulse is issued.

## Test plan
- **Reset**: hold `rst_n`=0 for 3 cycles with `en`=1 → `cnt`=0, `duty`=0, `busy`=0, `done`=0, `cmd_ready`=1, `period_start`=1.
- **Ramp up**: from `duty`=0, send target=3, rate=1 → `duty` becomes 1, 2, 3 at the 2nd, 4th and 6th boundary edges after accept; `done` pulses once, coincident with `duty`=3 and `cnt`=0; `busy` is high throughout; `cmd_valid` offered mid-ramp is not accepted.
- **Jump and clamp**: send target=120, rate=0 → `duty`=100 at the first boundary. Then send target=40, rate=0 → `duty`=40 at the next boundary. Never any intermediate values.
- **Equal target**: at `duty`=40, send target=40 → `done`=1 the next cycle, `busy` stays 0, `duty` unchanged.
- **Freeze**: during a ramp 40→42 at rate=0… instead use rate=2; drop `en` for 500 cycles mid-ramp → `cnt`, `duty` and `busy` are held and `cmd_ready`=0. After `en` returns, the step schedule resumes with no lost or extra boundary.
- **Reset mid-ramp**: assert `rst_n`=0 for one edge during a ramp → next cycle `duty`=0, `busy`=0, `cnt`=0, and no `done` pulse.

Source files
------------

// File: rtl/pwm_ramp_sequencer.sv
// Duty-cycle sequencer: owns the PWM period counter and walks the applied duty
// toward a commanded target one percent at a time, only on period boundaries.
module pwm_ramp_sequencer #(
    parameter int CNT_W  = 8,
    parameter int DC_MAX = 100
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [6:0]       i_cmd_target,
    input  logic [3:0]       i_cmd_rate,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_period_start,
    output logic [6:0]       o_duty,
    output logic             o_busy,
    output logic             o_done
);

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [6:0]       r_duty;
    logic [6:0]       r_tgt;
    logic [3:0]       r_rate;
    logic [3:0]       r_wait;
    logic             r_busy;
    logic             r_done;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [6:0]       w_duty_nxt;
    logic [6:0]       w_tgt_nxt;
    logic [3:0]       w_rate_nxt;
    logic [3:0]       w_wait_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic [6:0]       w_step;
    logic [6:0]       w_tgt_clamp;
    logic             w_boundary;
    logic             w_accept;

    assign o_cmd_ready    = i_en && (r_state == IDLE);
    assign w_accept       = i_cmd_valid && o_cmd_ready;
    assign w_boundary     = i_en && (r_cnt == {CNT_W{1'b1}});
    assign w_tgt_clamp    = (i_cmd_target > 7'(DC_MAX)) ? 7'(DC_MAX) : i_cmd_target;

    assign o_cnt          = r_cnt;
    assign o_period_start = (r_cnt == '0);
    assign o_duty         = r_duty;
    assign o_busy         = r_busy;
    assign o_done         = r_done;

    // done is a single-cycle pulse regardless of en, so its default is 0
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_duty_nxt  = r_duty;
        w_tgt_nxt   = r_tgt;
        w_rate_nxt  = r_rate;
        w_wait_nxt  = r_wait;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_step      = r_duty;

        if (i_en) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        w_tgt_nxt  = w_tgt_clamp;
                        w_rate_nxt = i_cmd_rate;
                        w_wait_nxt = i_cmd_rate;
                        if (w_tgt_clamp == r_duty) begin
                            w_done_nxt = 1'b1;
                        end else begin
                            w_state_nxt = RAMP;
                            w_busy_nxt  = 1'b1;
                        end
                    end
                end
                RAMP: begin
                    if (w_boundary) begin
                        if (r_rate == 4'd0) begin
                            w_step = r_tgt;
                        end else if (r_wait != 4'd0) begin
                            w_wait_nxt = r_wait - 4'd1;
                        end else begin
                            // In RAMP duty never equals the target, so one step cannot overshoot
                            w_step     = (r_duty < r_tgt) ? r_duty + 7'd1 : r_duty - 7'd1;
                            w_wait_nxt = r_rate;
                        end
                        w_duty_nxt = w_step;
                        if (w_step == r_tgt) begin
                            w_state_nxt = IDLE;
                            w_busy_nxt  = 1'b0;
                            w_done_nxt  = 1'b1;
                        end
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_duty  <= 7'd0;
            r_tgt   <= 7'd0;
            r_rate  <= 4'd0;
            r_wait  <= 4'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_duty  <= w_duty_nxt;
            r_tgt   <= w_tgt_nxt;
            r_rate  <= w_rate_nxt;
            r_wait  <= w_wait_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Directed bench for pwm_ramp_sequencer: reset, ramp pacing, jump/clamp,
// equal target, freeze with en=0 and reset mid-ramp.
module tb_pwm_ramp_sequencer;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic       en = 1'b1;
    logic       cmdValid = 1'b0;
    logic       cmdReady;
    logic [6:0] cmdTarget = 7'd0;
    logic [3:0] cmdRate = 4'd0;
    logic [7:0] cnt;
    logic       periodStart;
    logic [6:0] duty;
    logic       busy;
    logic       done;

    int total = 0;
    int bad = 0;
    int doneCount = 0;
    int dutyChanges = 0;
    logic [6:0] prevDuty = 7'd0;

    pwm_ramp_sequencer #(.CNT_W(8), .DC_MAX(100)) dut (
        .i_clk          (clk),
        .i_rst_n        (rstN),
        .i_en           (en),
        .i_cmd_valid    (cmdValid),
        .o_cmd_ready    (cmdReady),
        .i_cmd_target   (cmdTarget),
        .i_cmd_rate     (cmdRate),
        .o_cnt          (cnt),
        .o_period_start (periodStart),
        .o_duty         (duty),
        .o_busy         (busy),
        .o_done         (done)
    );

    always #5 clk = ~clk;

    // Count done pulses and duty changes, sampled just after each rising edge
    always @(posedge clk) begin
        #1;
        if (done === 1'b1) doneCount++;
        if (duty !== prevDuty) dutyChanges++;
        prevDuty = duty;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Step to the next cycle where cnt==0, i.e. just past a boundary edge
    task automatic next_period(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (cnt != 8'd0 && cycles < 400);
        if (cnt != 8'd0) begin
            total++; bad++;
            $display("[TB] FAIL period_timeout got=%0d exp=0", cnt);
        end
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        en = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (cnt !== 8'd0) begin bad++; $display("[TB] FAIL reset_cnt got=%0d exp=0", cnt); end
        total++; if (duty !== 7'd0) begin bad++; $display("[TB] FAIL reset_duty got=%0d exp=0", duty); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got=%b exp=0", done); end
        total++; if (cmdReady !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready got=%b exp=1", cmdReady); end
        total++; if (periodStart !== 1'b1) begin bad++; $display("[TB] FAIL reset_pstart got=%b exp=1", periodStart); end
        rstN = 1'b1;
    endtask

    task automatic test_ramp_up();
        int cyc;
        int dc0;
        logic [6:0] expDuty;
        dc0 = doneCount;
        cmdValid = 1'b1; cmdTarget = 7'd3; cmdRate = 4'd1;
        total++; if (cmdReady !== 1'b1) begin bad++; $display("[TB] FAIL ramp_ready got=%b exp=1", cmdReady); end
        @(negedge clk);
        cmdValid = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL ramp_busy_rise got=%b exp=1", busy); end
        for (int k = 1; k <= 6; k++) begin
            next_period(cyc);
            expDuty = 7'(k / 2);
            total++; if (duty !== expDuty) begin bad++; $display("[TB] FAIL ramp_duty_b%0d got=%0d exp=%0d", k, duty, expDuty); end
            total++; if (done !== (k == 6)) begin bad++; $display("[TB] FAIL ramp_done_b%0d got=%b exp=%b", k, done, (k == 6)); end
            total++; if (busy !== (k != 6)) begin bad++; $display("[TB] FAIL ramp_busy_b%0d got=%b exp=%b", k, busy, (k != 6)); end
            if (k == 3) begin
                cmdValid = 1'b1; cmdTarget = 7'd50; cmdRate = 4'd0;
                total++; if (cmdReady !== 1'b0) begin bad++; $display("[TB] FAIL ramp_midready got=%b exp=0", cmdReady); end
                @(negedge clk);
                cmdValid = 1'b0;
            end
        end
        @(negedge clk);
        total++; if (doneCount - dc0 !== 1) begin bad++; $display("[TB] FAIL ramp_done_count got=%0d exp=1", doneCount - dc0); end
        total++; if (duty !== 7'd3) begin bad++; $display("[TB] FAIL ramp_final got=%0d exp=3", duty); end
        next_period(cyc);
    endtask

    task automatic test_jump_clamp();
        int cyc;
        int ch0;
        ch0 = dutyChanges;
        cmdValid = 1'b1; cmdTarget = 7'd120; cmdRate = 4'd0;
        @(negedge clk);
        cmdValid = 1'b0;
        total++; if (duty !== 7'd3) begin bad++; $display("[TB] FAIL jump_hold got=%0d exp=3", duty); end
        next_period(cyc);
        total++; if (duty !== 7'd100) begin bad++; $display("[TB] FAIL jump_clamp got=%0d exp=100", duty); end
        total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL jump_done got=%b exp=1", done); end
        // back-to-back: issue the next command in the done cycle
        cmdValid = 1'b1; cmdTarget = 7'd40; cmdRate = 4'd0;
        total++; if (cmdReady !== 1'b1) begin bad++; $display("[TB] FAIL b2b_ready got=%b exp=1", cmdReady); end
        @(negedge clk);
        cmdValid = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL b2b_busy got=%b exp=1", busy); end
        next_period(cyc);
        total++; if (duty !== 7'd40) begin bad++; $display("[TB] FAIL jump_down got=%0d exp=40", duty); end
        total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL jump_down_done got=%b exp=1", done); end
        @(negedge clk);
        total++; if (dutyChanges - ch0 !== 2) begin bad++; $display("[TB] FAIL jump_changes got=%0d exp=2", dutyChanges - ch0); end
    endtask

    task automatic test_equal_target();
        cmdValid = 1'b1; cmdTarget = 7'd40; cmdRate = 4'd5;
        @(negedge clk);
        cmdValid = 1'b0;
        total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL equal_done got=%b exp=1", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL equal_busy got=%b exp=0", busy); end
        total++; if (duty !== 7'd40) begin bad++; $display("[TB] FAIL equal_duty got=%0d exp=40", duty); end
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL equal_done_clear got=%b exp=0", done); end
    endtask

    task automatic test_freeze();
        int cyc;
        int dc0;
        logic [6:0] expDuty;
        next_period(cyc);
        cmdValid = 1'b1; cmdTarget = 7'd42; cmdRate = 4'd2;
        @(negedge clk);
        cmdValid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            next_period(cyc);
            expDuty = (k == 3) ? 7'd41 : 7'd40;
            total++; if (duty !== expDuty) begin bad++; $display("[TB] FAIL freeze_pre_b%0d got=%0d exp=%0d", k, duty, expDuty); end
        end
        repeat (100) @(negedge clk);
        en = 1'b0;
        dc0 = doneCount;
        repeat (500) @(negedge clk);
        total++; if (cnt !== 8'd100) begin bad++; $display("[TB] FAIL freeze_cnt got=%0d exp=100", cnt); end
        total++; if (duty !== 7'd41) begin bad++; $display("[TB] FAIL freeze_duty got=%0d exp=41", duty); end
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL freeze_busy got=%b exp=1", busy); end
        total++; if (cmdReady !== 1'b0) begin bad++; $display("[TB] FAIL freeze_ready got=%b exp=0", cmdReady); end
        total++; if (doneCount !== dc0) begin bad++; $display("[TB] FAIL freeze_done got=%0d exp=%0d", doneCount, dc0); end
        en = 1'b1;
        next_period(cyc);
        total++; if (cyc !== 156) begin bad++; $display("[TB] FAIL freeze_resume_cycles got=%0d exp=156", cyc); end
        for (int k = 4; k <= 6; k++) begin
            if (k > 4) next_period(cyc);
            expDuty = (k == 6) ? 7'd42 : 7'd41;
            total++; if (duty !== expDuty) begin bad++; $display("[TB] FAIL freeze_post_b%0d got=%0d exp=%0d", k, duty, expDuty); end
            total++; if (done !== (k == 6)) begin bad++; $display("[TB] FAIL freeze_done_b%0d got=%b exp=%b", k, done, (k == 6)); end
        end
    endtask

    task automatic test_reset_mid_ramp();
        int dc0;
        cmdValid = 1'b1; cmdTarget = 7'd90; cmdRate = 4'd0;
        @(negedge clk);
        cmdValid = 1'b0;
        repeat (10) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL rmid_busy_pre got=%b exp=1", busy); end
        dc0 = doneCount;
        rstN = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        total++; if (duty !== 7'd0) begin bad++; $display("[TB] FAIL rmid_duty got=%0d exp=0", duty); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rmid_busy got=%b exp=0", busy); end
        total++; if (cnt !== 8'd0) begin bad++; $display("[TB] FAIL rmid_cnt got=%0d exp=0", cnt); end
        total++; if (cmdReady !== 1'b1) begin bad++; $display("[TB] FAIL rmid_ready got=%b exp=1", cmdReady); end
        repeat (300) @(negedge clk);
        total++; if (doneCount !== dc0) begin bad++; $display("[TB] FAIL rmid_no_done got=%0d exp=%0d", doneCount, dc0); end
        total++; if (duty !== 7'd0) begin bad++; $display("[TB] FAIL rmid_duty_hold got=%0d exp=0", duty); end
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_jump_clamp();
        test_equal_target();
        test_freeze();
        test_reset_mid_ramp();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
